// File: rtl/spi_ctrl_fsm_pkg.sv
// ----------------------------------------------------------------------------
// spi_defs: definitions shared by the SPI transfer sequencer (spi_ctrl_fsm)
// and the SPI datapath.
//   type_spi_states_e : sequencer state encoding (3 bits, observed by datapath)
//   SPI_CNT_W         : width of the SCLK half-period counter / period register
//   SPI_EDGE_CNT      : SCLK edges per byte (8 bits x 2 edges)
// ----------------------------------------------------------------------------
package spi_defs;

    localparam int unsigned SPI_CNT_W    = 12;
    localparam int unsigned SPI_EDGE_CNT = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_TRANS = 3'd2,
        ST_DONE  = 3'd3
    } type_spi_states_e;

endpackage

// File: rtl/spi_ctrl_fsm_if.sv
// ----------------------------------------------------------------------------
// spi_ctrl_fsm_if: FIFO handshake between the transfer sequencer and the
// datapath FIFOs.
//   tx_fifo_empty : tx FIFO holds no byte
//   tx_fifo_read  : one-cycle pop of the tx FIFO
//   rx_fifo_write : one-cycle push of the rx shift register into the rx FIFO
// master = sequencer side, slave = FIFO side.
// ----------------------------------------------------------------------------
interface spi_ctrl_fsm_if;

    logic tx_fifo_empty;
    logic tx_fifo_read;
    logic rx_fifo_write;

    modport master (
        input  tx_fifo_empty,
        output tx_fifo_read,
        output rx_fifo_write
    );

    modport slave (
        output tx_fifo_empty,
        input  tx_fifo_read,
        input  rx_fifo_write
    );

endinterface

// File: rtl/spi_ctrl_fsm_sclk_div.sv
// ----------------------------------------------------------------------------
// spi_sclk_div: SCLK half-period divider and edge counter.
//   clk, rst_n : system clock, async active-low reset
//   clear      : force counter, SCLK level and edge count to 0
//   count_en   : run the half-period counter (0..period, then wrap)
//   toggle_en  : on wrap, toggle SCLK and count the edge
//   period     : half-period in clk cycles minus 1
//   clock_cnt  : half-period counter
//   spi_clk    : unpolarised SCLK level
//   wrap       : counter is at period this cycle (comb)
//   last_edge  : the next toggle is the final edge of the byte (comb)
// ----------------------------------------------------------------------------
module spi_sclk_div
    import spi_defs::*;
#(
    parameter int unsigned CNT_W    = SPI_CNT_W,
    parameter int unsigned EDGE_CNT = SPI_EDGE_CNT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             count_en,
    input  logic             toggle_en,
    input  logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] clock_cnt,
    output logic             spi_clk,
    output logic             wrap,
    output logic             last_edge
);

    localparam int unsigned EDGE_W = $clog2(EDGE_CNT);

    logic [EDGE_W-1:0] edge_cnt;

    // Equality compare: period must not change while a byte is in flight.
    assign wrap      = count_en && (clock_cnt == period);
    assign last_edge = (edge_cnt == EDGE_W'(EDGE_CNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clock_cnt <= '0;
            spi_clk   <= 1'b0;
            edge_cnt  <= '0;
        end else if (clear) begin
            clock_cnt <= '0;
            spi_clk   <= 1'b0;
            edge_cnt  <= '0;
        end else if (count_en) begin
            if (wrap) begin
                clock_cnt <= '0;
            end else begin
                clock_cnt <= clock_cnt + 1'b1;
            end
            if (wrap && toggle_en) begin
                // Final edge parks SCLK at idle and re-arms the edge count.
                if (last_edge) begin
                    spi_clk  <= 1'b0;
                    edge_cnt <= '0;
                end else begin
                    spi_clk  <= ~spi_clk;
                    edge_cnt <= edge_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// spi_ctrl_fsm: SPI transfer sequencer. Pops one tx byte per transfer, times
// the 16 SCLK half-periods, pushes the received byte to the rx FIFO.
//   clk, rst_n       : system clock, async active-low reset
//   spi_enable       : controller enabled
//   spi_clk_period   : SCLK half-period in clk cycles minus 1
//   spi_clk_polarity : CPOL, SCLK idle level
//   spi_clk_phase    : CPHA (does not alter sequencing)
//   fifo             : tx_fifo_empty in, tx_fifo_read / rx_fifo_write out
//   state_ff_o       : registered state
//   state_next_o     : combinational next state
//   clock_cnt_o      : half-period counter
//   spi_clk_o        : unpolarised SCLK
//   sclk_o           : pad SCLK (spi_clk_o ^ CPOL)
//   ss_n_o           : slave select, active low (registered)
//   busy_o           : state != IDLE
//   xfer_done_o      : one-cycle pulse per completed byte
// ----------------------------------------------------------------------------
module spi_ctrl_fsm
    import spi_defs::*;
#(
    parameter int unsigned CNT_W    = SPI_CNT_W,
    parameter int unsigned EDGE_CNT = SPI_EDGE_CNT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_enable,
    input  logic [CNT_W-1:0]      spi_clk_period,
    input  logic                  spi_clk_polarity,
    input  logic                  spi_clk_phase,
    spi_ctrl_fsm_if.master        fifo,
    output logic [2:0]            state_ff_o,
    output logic [2:0]            state_next_o,
    output logic [CNT_W-1:0]      clock_cnt_o,
    output logic                  spi_clk_o,
    output logic                  sclk_o,
    output logic                  ss_n_o,
    output logic                  busy_o,
    output logic                  xfer_done_o
);

    type_spi_states_e state_ff;
    type_spi_states_e state_next;

    logic div_clear;
    logic div_count_en;
    logic div_toggle_en;
    logic div_wrap;
    logic div_last_edge;
    logic start_ok;

    // CPHA only moves which edge samples; a byte is always 16 edges long.
    logic unused_phase;
    assign unused_phase = spi_clk_phase;

    assign start_ok = spi_enable && !fifo.tx_fifo_empty;

    always_comb begin
        state_next         = ST_IDLE;
        fifo.tx_fifo_read  = 1'b0;
        fifo.rx_fifo_write = 1'b0;
        case (state_ff)
            ST_IDLE: begin
                state_next = start_ok ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                // Pop coincides with the edge that enters TRANS so the
                // datapath loads MOSI as the first half-period begins.
                if (div_wrap) begin
                    state_next        = ST_TRANS;
                    fifo.tx_fifo_read = 1'b1;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_TRANS: begin
                state_next = (div_wrap && div_last_edge) ? ST_DONE : ST_TRANS;
            end
            ST_DONE: begin
                fifo.rx_fifo_write = 1'b1;
                state_next         = start_ok ? ST_WAIT : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_ff <= ST_IDLE;
            ss_n_o   <= 1'b1;
        end else begin
            state_ff <= state_next;
            // Following state_next keeps ss_n low across back-to-back bytes.
            ss_n_o   <= (state_next == ST_IDLE);
        end
    end

    assign div_count_en  = (state_ff == ST_WAIT) || (state_ff == ST_TRANS);
    assign div_toggle_en = (state_ff == ST_TRANS);
    assign div_clear     = !div_count_en;

    spi_sclk_div #(
        .CNT_W    (CNT_W),
        .EDGE_CNT (EDGE_CNT)
    ) u_sclk_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (div_clear),
        .count_en  (div_count_en),
        .toggle_en (div_toggle_en),
        .period    (spi_clk_period),
        .clock_cnt (clock_cnt_o),
        .spi_clk   (spi_clk_o),
        .wrap      (div_wrap),
        .last_edge (div_last_edge)
    );

    assign state_ff_o   = state_ff;
    assign state_next_o = state_next;
    assign sclk_o       = spi_clk_o ^ spi_clk_polarity;
    assign busy_o       = (state_ff != ST_IDLE);
    assign xfer_done_o  = (state_ff == ST_DONE);

endmodule

// File: tb/tb_spi_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_spi_ctrl_fsm: directed bench for spi_ctrl_fsm. A counting tx FIFO model
// (bytes queued vs. bytes popped) drives tx_fifo_empty.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_enable = 1'b0;
    logic        cpol = 1'b0;
    logic        cpha = 1'b0;
    logic [11:0] period = '0;

    logic [2:0]  state_ff;
    logic [2:0]  state_next;
    logic [11:0] clock_cnt;
    logic        spi_clk;
    logic        sclk;
    logic        ss_n;
    logic        busy;
    logic        xfer_done;

    int queued = 0;
    int pops = 0;
    int rd_empty_bad = 0;

    int n_vec = 0;
    int n_err = 0;

    int rd_q[$];
    int wr_q[$];
    int toggles, ss_bad, pad_bad, pulse_bad, end_cyc, cnt_at_rd;

    spi_ctrl_fsm_if fifo ();

    assign fifo.tx_fifo_empty = (queued == pops);

    spi_ctrl_fsm #(
        .CNT_W    (12),
        .EDGE_CNT (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .spi_enable       (spi_enable),
        .spi_clk_period   (period),
        .spi_clk_polarity (cpol),
        .spi_clk_phase    (cpha),
        .fifo             (fifo.master),
        .state_ff_o       (state_ff),
        .state_next_o     (state_next),
        .clock_cnt_o      (clock_cnt),
        .spi_clk_o        (spi_clk),
        .sclk_o           (sclk),
        .ss_n_o           (ss_n),
        .busy_o           (busy),
        .xfer_done_o      (xfer_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo.tx_fifo_read === 1'b1) begin
            pops <= pops + 1;
            if (fifo.tx_fifo_empty) rd_empty_bad <= rd_empty_bad + 1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the cycle current at call time; stops at the first return
    // to IDLE (stop_at < 0) or at cycle stop_at.
    task automatic run_xfer(input int max_cyc, input int dis_at, input int stop_at);
        logic prev;
        bit   done;
        done = 1'b0;
        rd_q.delete();
        wr_q.delete();
        toggles = 0; ss_bad = 0; pad_bad = 0; pulse_bad = 0;
        end_cyc = -1; cnt_at_rd = -1;
        prev = sclk;
        for (int cyc = 0; cyc <= max_cyc; cyc++) begin
            if ((stop_at >= 0 && cyc == stop_at) ||
                (stop_at < 0 && cyc > 0 && state_ff == 3'd0)) begin
                end_cyc = cyc;
                done = 1'b1;
                break;
            end
            if (fifo.tx_fifo_read === 1'b1) begin
                rd_q.push_back(cyc);
                cnt_at_rd = int'(clock_cnt);
            end
            if (fifo.rx_fifo_write === 1'b1) wr_q.push_back(cyc);
            if (sclk !== prev) toggles++;
            prev = sclk;
            if (ss_n !== (state_ff == 3'd0)) ss_bad++;
            if (sclk !== (spi_clk ^ cpol)) pad_bad++;
            if (busy !== (state_ff != 3'd0)) pad_bad++;
            if ((xfer_done !== fifo.rx_fifo_write) ||
                (fifo.tx_fifo_read === 1'b1 && fifo.rx_fifo_write === 1'b1)) pulse_bad++;
            if (cyc == dis_at) spi_enable = 1'b0;
            tick();
        end
        check("run_timeout", 32'(done), 32'd1);
    endtask

    int pops0;
    int bad;

    initial begin
        // ---- reset ----
        period = 12'd3;
        repeat (3) tick();
        check("rst_state", 32'(state_ff), 0);
        check("rst_ss_n", 32'(ss_n), 1);
        check("rst_cnt", 32'(clock_cnt), 0);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd", 32'(fifo.tx_fifo_read), 0);
        check("rst_wr", 32'(fifo.rx_fifo_write), 0);
        rst_n = 1'b1;
        tick();

        // ---- 1: period 3, one byte ----
        spi_enable = 1'b1;
        queued += 1;
        #1;
        check("t1_next_wait", 32'(state_next), 1);
        run_xfer(300, -1, -1);
        check("t1_nrd", rd_q.size(), 1);
        if (rd_q.size() > 0) check("t1_rd_cyc", rd_q[0], 4);
        check("t1_cnt_at_rd", cnt_at_rd, 3);
        check("t1_nwr", wr_q.size(), 1);
        if (wr_q.size() > 0) check("t1_wr_cyc", wr_q[0], 69);
        check("t1_toggles", toggles, 16);
        check("t1_end", end_cyc, 70);
        check("t1_ss_bad", ss_bad, 0);
        check("t1_pad_bad", pad_bad, 0);
        check("t1_pulse_bad", pulse_bad, 0);
        check("t1_ss_idle", 32'(ss_n), 1);

        // ---- 2: period 0, three bytes back-to-back ----
        period = 12'd0;
        pops0 = pops;
        queued += 3;
        run_xfer(300, -1, -1);
        check("t2_nrd", rd_q.size(), 3);
        check("t2_nwr", wr_q.size(), 3);
        if (rd_q.size() == 3) begin
            check("t2_rd0", rd_q[0], 1);
            check("t2_rd1", rd_q[1], 19);
            check("t2_rd2", rd_q[2], 37);
        end
        if (wr_q.size() == 3) begin
            check("t2_wr0", wr_q[0], 18);
            check("t2_wr1", wr_q[1], 36);
            check("t2_wr2", wr_q[2], 54);
        end
        check("t2_toggles", toggles, 48);
        check("t2_end", end_cyc, 55);
        check("t2_ss_bad", ss_bad, 0);
        check("t2_pops", pops - pops0, 3);

        // ---- 3: CPOL=1, period 1 ----
        cpol = 1'b1;
        period = 12'd1;
        #1;
        check("t3_sclk_idle", 32'(sclk), 1);
        queued += 1;
        run_xfer(300, -1, -1);
        if (rd_q.size() > 0) check("t3_rd_cyc", rd_q[0], 2);
        if (wr_q.size() > 0) check("t3_wr_cyc", wr_q[0], 35);
        check("t3_toggles", toggles, 16);
        check("t3_end", end_cyc, 36);
        check("t3_pad_bad", pad_bad, 0);
        check("t3_sclk_after", 32'(sclk), 1);
        cpol = 1'b0;

        // ---- 4: disable mid-byte with two queued ----
        pops0 = pops;
        queued += 2;
        run_xfer(300, 13, -1);
        check("t4_nrd", rd_q.size(), 1);
        check("t4_nwr", wr_q.size(), 1);
        if (wr_q.size() > 0) check("t4_wr_cyc", wr_q[0], 35);
        check("t4_end", end_cyc, 36);
        repeat (5) tick();
        check("t4_idle", 32'(state_ff), 0);
        check("t4_pops", pops - pops0, 1);
        queued = pops;

        // ---- 5: reset during edge 9 ----
        spi_enable = 1'b1;
        queued += 1;
        run_xfer(300, -1, 20);
        check("t5_pre_state", 32'(state_ff), 2);
        rst_n = 1'b0;
        #1;
        check("t5_rst_state", 32'(state_ff), 0);
        check("t5_rst_ss_n", 32'(ss_n), 1);
        check("t5_rst_cnt", 32'(clock_cnt), 0);
        check("t5_rst_spiclk", 32'(spi_clk), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_wr", 32'(fifo.rx_fifo_write), 0);
        check("t5_no_wr", wr_q.size(), 0);
        tick();
        rst_n = 1'b1;
        queued += 1;
        #1;
        check("t5_next_wait", 32'(state_next), 1);
        run_xfer(300, -1, -1);
        if (rd_q.size() > 0) check("t5_rd_cyc", rd_q[0], 2);
        if (wr_q.size() > 0) check("t5_wr_cyc", wr_q[0], 35);
        check("t5_end", end_cyc, 36);

        // ---- 6: enabled with empty FIFO, byte arrives later ----
        period = 12'd0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (state_ff != 3'd0 || fifo.tx_fifo_read !== 1'b0 ||
                fifo.rx_fifo_write !== 1'b0 || ss_n !== 1'b1) bad++;
        end
        check("t6_empty_idle", bad, 0);
        queued += 1;
        #1;
        check("t6_next_wait", 32'(state_next), 1);
        tick();
        check("t6_wait", 32'(state_ff), 1);
        check("t6_ss_low", 32'(ss_n), 0);
        run_xfer(300, -1, -1);
        if (rd_q.size() > 0) check("t6_rd_cyc", rd_q[0], 0);
        if (wr_q.size() > 0) check("t6_wr_cyc", wr_q[0], 17);
        check("t6_end", end_cyc, 18);

        check("rd_when_empty", rd_empty_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
